// File: rtl/pixel_fetch_dma_pkg.sv
// rtl/pixel_fetch_dma_pkg.sv - shared state encodings and descriptor type for pixel_fetch_dma
package pixel_fetch_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    typedef logic [1:0] fetch_state_e;

    // Wide enough for any supported MAX_WORDS_W (up to 16).
    localparam int DESC_COUNT_W = 16;

    typedef struct packed {
        logic [23:1]             addr;
        logic [DESC_COUNT_W-1:0] count;
    } fetch_desc_s;

endpackage

// File: rtl/pixel_fetch_dma_byte_fifo.sv
// rtl/pixel_fetch_dma_byte_fifo.sv - byte FIFO with a 2-byte push port and a 1-byte pop port
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [15:0]              push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;

    // High byte lands at the lower position so it is popped first.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]               <= push_data[15:8];
            mem[wr_ptr + PTR_W'(1)]   <= push_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(2);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (push ? OCC_W'(2) : OCC_W'(0)) - (pop ? OCC_W'(1) : OCC_W'(0));
        end
    end

    assign head      = mem[rd_ptr];
    assign occupancy = count;

endmodule

// File: rtl/pixel_fetch_dma.sv
// rtl/pixel_fetch_dma.sv - bus68k read master feeding a pixel stream; PIXEL_FETCH_CLUT4_EN selects 4-bit pixels
module pixel_fetch_dma
    import pixel_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_WORDS_W = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [22:0]            start_addr,
    input  logic [MAX_WORDS_W-1:0] word_count,
    output logic                   busy,
    output logic                   done,
    output logic                   bus_as,
    output logic                   bus_uds,
    output logic                   bus_lds,
    output logic                   bus_write_strobe,
    output logic [23:1]            bus_addr,
    output logic [15:0]            bus_data_out,
    input  logic [15:0]            bus_data_in,
    input  logic                   bus_ack,
    output logic                   pix_write,
    output logic [7:0]             pix_pixel,
    input  logic                   pix_strobe
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e state;
    fetch_desc_s  desc;
    logic         as_q;
    logic [23:1]  addr_q;
    logic         busy_q;
    logic         done_q;

    logic             push;
    logic             pop;
    logic             consume;
    logic             fifo_empty;
    logic             room;
    logic [7:0]       head;
    logic [OCC_W-1:0] occupancy;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (bus_data_in),
        .pop       (pop),
        .head      (head),
        .occupancy (occupancy)
    );

    assign push       = as_q & bus_ack;
    assign fifo_empty = (occupancy == '0);
    // Registered occupancy ignores this cycle's pop, so the check is conservative.
    assign room       = (occupancy <= OCC_W'(FIFO_DEPTH - 2));
    assign pix_write  = ~fifo_empty;
    assign consume    = pix_write & pix_strobe;

`ifdef PIXEL_FETCH_CLUT4_EN
    logic nib_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            nib_sel <= 1'b0;
        end else if (consume) begin
            nib_sel <= ~nib_sel;
        end
    end

    assign pop       = consume & nib_sel;
    assign pix_pixel = fifo_empty ? 8'h00 : {4'h0, (nib_sel ? head[3:0] : head[7:4])};
`else
    assign pop       = consume;
    assign pix_pixel = fifo_empty ? 8'h00 : head;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            desc   <= '0;
            as_q   <= 1'b0;
            addr_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            desc.addr  <= start_addr;
                            desc.count <= DESC_COUNT_W'(word_count);
                            busy_q     <= 1'b1;
                            state      <= REQ;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (as_q) begin
                        if (bus_ack) begin
                            as_q       <= 1'b0;
                            desc.addr  <= desc.addr + 23'd1;
                            desc.count <= desc.count - DESC_COUNT_W'(1);
                            if (desc.count == DESC_COUNT_W'(1)) begin
                                state <= DRAIN;
                            end
                        end
                    end else if (room) begin
                        as_q   <= 1'b1;
                        addr_q <= desc.addr;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign bus_as           = as_q;
    assign bus_uds          = as_q;
    assign bus_lds          = as_q;
    assign bus_write_strobe = 1'b0;
    assign bus_addr         = addr_q;
    assign bus_data_out     = 16'h0000;

endmodule
